// File: rtl/fpnew_sdotp_acc_sequencer.sv
// rtl/fpnew_sdotp_acc_sequencer.sv - issue sequencer that chains SDOTP ops through a running accumulator
module fpnew_sdotp_acc_sequencer #(
    parameter int LaneWidth = 64,
    parameter int LenWidth  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [LenWidth-1:0]    job_len_i,
    input  logic [LaneWidth-1:0]   job_acc_i,
    input  logic                   beat_valid_i,
    output logic                   beat_ready_o,
    input  logic [LaneWidth-1:0]   beat_a_i,
    input  logic [LaneWidth-1:0]   beat_b_i,
    input  logic                   flush_i,
    output logic                   dotp_valid_o,
    input  logic                   dotp_ready_i,
    output logic [3*LaneWidth-1:0] dotp_operands_o,
    input  logic                   dotp_valid_i,
    output logic                   dotp_ready_o,
    input  logic [LaneWidth-1:0]   dotp_result_i,
    input  logic [4:0]             dotp_status_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [LaneWidth-1:0]   res_o,
    output logic [4:0]             status_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [LaneWidth-1:0] acc_q;
    logic [LenWidth-1:0]  cnt_q;
    logic [4:0]           status_q;

    logic job_fire;
    logic issue_fire;
    logic result_take;

    // A flush in the same cycle blocks job acceptance and beat consumption.
    assign job_fire    = (state_q == ST_IDLE) && job_valid_i && !flush_i;
    assign issue_fire  = (state_q == ST_ISSUE) && beat_valid_i && dotp_ready_i && !flush_i;
    assign result_take = (state_q == ST_WAIT) && dotp_valid_i && !flush_i;

    assign dotp_operands_o = {acc_q, beat_b_i, beat_a_i};
    assign res_o           = acc_q;
    assign status_o        = status_q;
    assign busy_o          = (state_q != ST_IDLE);

    // Next-state and handshake outputs; flush has priority over every other transition.
    always_comb begin
        state_d      = state_q;
        job_ready_o  = 1'b0;
        beat_ready_o = 1'b0;
        dotp_valid_o = 1'b0;
        dotp_ready_o = 1'b0;
        res_valid_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                job_ready_o = !flush_i;
                if (job_fire) begin
                    state_d = (job_len_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dotp_valid_o = beat_valid_i && !flush_i;
                beat_ready_o = dotp_ready_i && !flush_i;
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (issue_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dotp_ready_o = 1'b1;
                if (flush_i) begin
                    // A result taken in the flush cycle leaves nothing to drain.
                    state_d = dotp_valid_i ? ST_IDLE : ST_DRAIN;
                end else if (dotp_valid_i) begin
                    state_d = (cnt_q != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_DRAIN: begin
                dotp_ready_o = 1'b1;
                if (dotp_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                res_valid_o = !flush_i;
                if (flush_i || res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus accumulator, remaining-beat counter and sticky status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            if (job_fire) begin
                acc_q    <= job_acc_i;
                cnt_q    <= job_len_i;
                status_q <= '0;
            end
            if (issue_fire && (cnt_q != '0)) begin
                cnt_q <= cnt_q - LenWidth'(1);
            end
            if (result_take) begin
                acc_q    <= dotp_result_i;
                status_q <= status_q | dotp_status_i;
            end
        end
    end

    // The unit must only return results while one of ours is in flight.
    assert property (@(posedge clk_i) disable iff (rst_i)
        dotp_valid_i |-> ((state_q == ST_WAIT) || (state_q == ST_DRAIN)));

endmodule

// File: tb/tb_fpnew_sdotp_acc_sequencer.sv
// tb/tb_fpnew_sdotp_acc_sequencer.sv - directed bench for fpnew_sdotp_acc_sequencer
module tb_fpnew_sdotp_acc_sequencer;
    localparam int LW = 64;
    localparam int NW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            job_valid_i;
    logic            job_ready_o;
    logic [NW-1:0]   job_len_i;
    logic [LW-1:0]   job_acc_i;
    logic            beat_valid_i;
    logic            beat_ready_o;
    logic [LW-1:0]   beat_a_i;
    logic [LW-1:0]   beat_b_i;
    logic            flush_i;
    logic            dotp_valid_o;
    logic            dotp_ready_i;
    logic [3*LW-1:0] dotp_operands_o;
    logic            dotp_valid_i;
    logic            dotp_ready_o;
    logic [LW-1:0]   dotp_result_i;
    logic [4:0]      dotp_status_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [LW-1:0]   res_o;
    logic [4:0]      status_o;
    logic            busy_o;

    always #5 clk = ~clk;

    fpnew_sdotp_acc_sequencer #(.LaneWidth(LW), .LenWidth(NW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .job_valid_i    (job_valid_i),
        .job_ready_o    (job_ready_o),
        .job_len_i      (job_len_i),
        .job_acc_i      (job_acc_i),
        .beat_valid_i   (beat_valid_i),
        .beat_ready_o   (beat_ready_o),
        .beat_a_i       (beat_a_i),
        .beat_b_i       (beat_b_i),
        .flush_i        (flush_i),
        .dotp_valid_o   (dotp_valid_o),
        .dotp_ready_i   (dotp_ready_i),
        .dotp_operands_o(dotp_operands_o),
        .dotp_valid_i   (dotp_valid_i),
        .dotp_ready_o   (dotp_ready_o),
        .dotp_result_i  (dotp_result_i),
        .dotp_status_i  (dotp_status_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_o          (res_o),
        .status_o       (status_o),
        .busy_o         (busy_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    // SDOTP stand-in: returns operands[2]+1 mdl_delay cycles after issue, with a per-beat status.
    int          mdl_delay = 2;
    int          mdl_cnt   = 0;
    int          issue_cnt = 0;
    bit          mdl_busy  = 0;
    logic [LW-1:0] issued_acc [16];
    logic [4:0]    beat_status[16];
    logic [LW-1:0] pend_res;
    logic [4:0]    pend_st;

    always @(posedge clk) begin : sdotp_model
        logic            f_iss;
        logic            f_res;
        logic [3*LW-1:0] ops;
        f_iss = dotp_valid_o && dotp_ready_i;
        f_res = dotp_valid_i && dotp_ready_o;
        ops   = dotp_operands_o;
        #1;
        if (rst) begin
            dotp_valid_i = 1'b0;
            mdl_busy     = 0;
        end else begin
            if (f_res) begin
                dotp_valid_i = 1'b0;
                mdl_busy     = 0;
            end
            if (f_iss) begin
                if (issue_cnt < 16) begin
                    issued_acc[issue_cnt] = ops[3*LW-1:2*LW];
                    pend_st = beat_status[issue_cnt];
                end else begin
                    pend_st = 5'd0;
                end
                pend_res  = ops[3*LW-1:2*LW] + 64'd1;
                issue_cnt = issue_cnt + 1;
                mdl_busy  = 1;
                mdl_cnt   = mdl_delay - 1;
            end else if (mdl_busy && !dotp_valid_i) begin
                mdl_cnt = mdl_cnt - 1;
            end
            if (mdl_busy && !dotp_valid_i && mdl_cnt <= 0) begin
                dotp_valid_i  = 1'b1;
                dotp_result_i = pend_res;
                dotp_status_i = pend_st;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [NW-1:0] len, input logic [LW-1:0] acc0);
        int t;
        issue_cnt = 0;
        t = 0;
        while (!job_ready_o && t < 50) begin
            step();
            t++;
        end
        job_valid_i = 1'b1;
        job_len_i   = len;
        job_acc_i   = acc0;
        step();
        job_valid_i = 1'b0;
    endtask

    task automatic wait_res(input string tag, output int lat);
        int t;
        t = 0;
        while (!res_valid_o && t < 500) begin
            step();
            t++;
        end
        lat = t;
        chk1({tag, " res_valid"}, res_valid_o, 1'b1);
    endtask

    task automatic take_res();
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [NW-1:0]  len;
        logic [LW-1:0]  acc0;
        logic [3:0][4:0] st;
        logic [LW-1:0]  exp_res;
        logic [4:0]     exp_st;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  lat;
        int  t;
        bit  saw_res;

        vecs[0] = '{len: 8'd3, acc0: 64'd10, st: {5'd0, 5'd0, 5'd0, 5'd0},
                    exp_res: 64'd13, exp_st: 5'd0};
        vecs[1] = '{len: 8'd2, acc0: 64'd100, st: {5'd0, 5'd0, 5'b00100, 5'b00001},
                    exp_res: 64'd102, exp_st: 5'b00101};
        vecs[2] = '{len: 8'd1, acc0: 64'd0, st: {5'd0, 5'd0, 5'd0, 5'd0},
                    exp_res: 64'd1, exp_st: 5'd0};
        vecs[3] = '{len: 8'd4, acc0: 64'hFFFF_FFFF_FFFF_FFFE, st: {5'b01000, 5'd0, 5'd0, 5'b10000},
                    exp_res: 64'd2, exp_st: 5'b11000};
        vecs[4] = '{len: 8'd0, acc0: 64'h3FF0_0000_0000_0000, st: {5'd0, 5'd0, 5'd0, 5'd0},
                    exp_res: 64'h3FF0_0000_0000_0000, exp_st: 5'd0};

        rst = 1'b1;
        job_valid_i = 1'b0; job_len_i = '0; job_acc_i = '0;
        beat_valid_i = 1'b1; beat_a_i = 64'hA; beat_b_i = 64'hB;
        flush_i = 1'b0; dotp_ready_i = 1'b1; res_ready_i = 1'b0;
        dotp_valid_i = 1'b0; dotp_result_i = '0; dotp_status_i = '0;
        for (int k = 0; k < 16; k++) beat_status[k] = 5'd0;
        step();
        step();
        rst = 1'b0;
        chk1("por job_ready", job_ready_o, 1'b1);
        chk1("por busy", busy_o, 1'b0);

        // Reset in the middle of a job.
        start_job(8'd3, 64'd10);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk1("rst job_ready", job_ready_o, 1'b1);
        chk1("rst busy", busy_o, 1'b0);
        chk1("rst res_valid", res_valid_o, 1'b0);
        chk1("rst dotp_valid", dotp_valid_o, 1'b0);
        chk1("rst dotp_ready", dotp_ready_o, 1'b0);
        chk64("rst acc", res_o, 64'd0);
        chk64("rst status", 64'(status_o), 64'd0);
        rst = 1'b0;
        step();

        // Table of whole jobs.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 16; k++) beat_status[k] = (k < 4) ? vecs[i].st[k] : 5'd0;
            start_job(vecs[i].len, vecs[i].acc0);
            wait_res($sformatf("vec%0d", i), lat);
            if (vecs[i].len == 8'd0) chki($sformatf("vec%0d latency", i), lat, 0);
            chk64($sformatf("vec%0d res", i), res_o, vecs[i].exp_res);
            chk64($sformatf("vec%0d status", i), 64'(status_o), 64'(vecs[i].exp_st));
            chki($sformatf("vec%0d issues", i), issue_cnt, int'(vecs[i].len));
            for (int k = 0; k < int'(vecs[i].len); k++)
                chk64($sformatf("vec%0d op2 beat%0d", i, k), issued_acc[k], vecs[i].acc0 + 64'(k));
            take_res();
            chk1($sformatf("vec%0d idle after", i), busy_o, 1'b0);
        end

        // Job presented with flush in IDLE is not accepted.
        flush_i = 1'b1;
        job_valid_i = 1'b1; job_len_i = 8'd1; job_acc_i = 64'd5;
        step();
        job_valid_i = 1'b0; flush_i = 1'b0;
        chk1("idle flush no accept", busy_o, 1'b0);

        // Backpressure on issue, then on the result.
        dotp_ready_i = 1'b0;
        beat_a_i = 64'h1111; beat_b_i = 64'h2222;
        start_job(8'd1, 64'd50);
        chk64("bp a", dotp_operands_o[LW-1:0], 64'h1111);
        chk64("bp b", dotp_operands_o[2*LW-1:LW], 64'h2222);
        for (int c = 0; c < 5; c++) begin
            chk1($sformatf("bp beat_ready c%0d", c), beat_ready_o, 1'b0);
            chk1($sformatf("bp dotp_valid c%0d", c), dotp_valid_o, 1'b1);
            chk64($sformatf("bp acc op c%0d", c), dotp_operands_o[3*LW-1:2*LW], 64'd50);
            step();
        end
        chki("bp no issue", issue_cnt, 0);
        dotp_ready_i = 1'b1;
        wait_res("bp", lat);
        for (int c = 0; c < 4; c++) begin
            chk1($sformatf("hold valid c%0d", c), res_valid_o, 1'b1);
            chk64($sformatf("hold res c%0d", c), res_o, 64'd51);
            step();
        end
        take_res();

        // Flush in ISSUE with a beat present: not consumed, not issued.
        beat_a_i = 64'hA; beat_b_i = 64'hB;
        start_job(8'd2, 64'd0);
        flush_i = 1'b1;
        #1;
        chk1("issue flush beat_ready", beat_ready_o, 1'b0);
        chk1("issue flush dotp_valid", dotp_valid_o, 1'b0);
        step();
        flush_i = 1'b0;
        chk1("issue flush idle", busy_o, 1'b0);
        chki("issue flush no issue", issue_cnt, 0);

        // Flush in WAIT: in-flight result drained, no final result.
        mdl_delay = 4;
        start_job(8'd2, 64'd0);
        t = 0;
        while (issue_cnt == 0 && t < 50) begin
            step();
            t++;
        end
        chki("wait flush issued", issue_cnt, 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk1("drain busy", busy_o, 1'b1);
        chk1("drain dotp_ready", dotp_ready_o, 1'b1);
        saw_res = 0;
        t = 0;
        while (mdl_busy && t < 50) begin
            if (res_valid_o) saw_res = 1;
            step();
            t++;
        end
        chk1("drain result consumed", mdl_busy, 1'b0);
        chk1("drain no res_valid", saw_res, 1'b0);
        chk1("drain back idle", busy_o, 1'b0);
        chki("drain single issue", issue_cnt, 1);
        mdl_delay = 2;

        start_job(8'd1, 64'd7);
        wait_res("post flush", lat);
        chk64("post flush res", res_o, 64'd8);
        chk64("post flush status", 64'(status_o), 64'd0);
        take_res();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
